vc_domain_arb2_ctrl: RTL and testbench
======================================

Name: vc_domain_arb2_ctrl

Overview:
- Two-requester, domain-aware arbiter that shares one vc_Mux2_sd-style datapath (in0/in1 -> out) between a domain-0 requester and a domain-1 requester.
- Generates the mux select and the {L} domain label.
- Enforces whole-transaction (multi-beat) ownership and round-robin fairness.
- Optionally inserts idle scrub cycles on every domain change, so no beat of one domain is adjacent to a beat of the other.
- Sits between two val/rdy producers and one shared downstream consumer.

Parameters:
- p_max_beats, 8: maximum beats per grant before forced release (watchdog); must be >= 2.
- p_scrub_cycles, 2: idle cycles inserted on a domain switch when the scrub feature is compiled in; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0_val  input  1  requester 0 (domain 0) has a beat.
- in0_last  input  1  current in0 beat is the last beat of its transaction.
- in0_rdy  output  1  in0 beat accepted this cycle.
- in1_val  input  1  requester 1 (domain 1) has a beat.
- in1_last  input  1  current in1 beat is the last beat of its transaction.
- in1_rdy  output  1  in1 beat accepted this cycle.
- out_val  output  1  shared output carries a valid beat.
- out_rdy  input  1  downstream accepts a beat.
- mux_sel  output  1  select to the shared mux: 0 = in0, 1 = in1.
- mux_domain  output  1  domain label to the shared mux; always equals mux_sel while granted.
- busy  output  1  high in any state other than IDLE.
- preempt  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- States: IDLE, GRANT0, GRANT1, SCRUB. All state is registered.
- Reset (async, immediate):
  - state=IDLE; prio=0 (in0 favoured); beat counter=0; scrub counter=0.
  - mux_sel=0, mux_domain=0, out_val=0, in0_rdy=0, in1_rdy=0, busy=0, preempt=0.
  - Reset mid-transaction aborts the grant with no further beats.
- IDLE:
  - Only inX_val -> GRANTX next cycle.
  - Both valid -> grant the requester indicated by prio.
  - Neither valid -> stay in IDLE.
  - Latency from val to the first possible rdy is one cycle.
- GRANTX:
  - out_val = inX_val; inX_rdy = inX_val & out_rdy; the other requester's rdy = 0.
  - mux_sel and mux_domain are registered and equal X.
  - A beat fires when inX_val & out_rdy. Each fire increments the beat counter.
- Release occurs on a fire with inX_last=1, or on a fire with the beat counter = p_max_beats-1. The second case is a watchdog release: preempt pulses in the following cycle.
- On release:
  - prio points to the other requester; the beat counter clears.
  - Other requester valid -> switch (SCRUB or direct GRANT, per the feature).
  - Else, same requester valid -> stay in GRANTX with a fresh transaction.
  - Else -> IDLE.
- No release while out_rdy=0; val held with rdy low simply stalls.
- Leaving IDLE for a different domain than the current mux_domain follows the same switch rule.
- SCRUB:
  - out_val=0, both rdy=0.
  - mux_sel and mux_domain keep the previous owner's values.
  - Runs exactly p_scrub_cycles cycles, then enters GRANT of the pending requester, even if its val has since dropped; in that case it goes GRANT -> IDLE when nothing fires.
- A GRANTX whose inX_val is low and whose beat counter is 0 returns to IDLE after one cycle (no wedge).
- Counters:
  - Beat counter: clog2(p_max_beats) bits; wraps only via clear.
  - Scrub counter: clog2(p_scrub_cycles+1) bits.

Optional Feature:
- Macro: VC_DOMAIN_ARB_SCRUB_EN.
- Defined: every domain change passes through SCRUB for p_scrub_cycles cycles, so the earliest other-domain beat is p_scrub_cycles+1 cycles after the last fire.
- Undefined: the SCRUB state is not built; release goes directly to the other GRANT next cycle, and the other domain's first beat can fire one cycle after the last fire.
- All other behaviour is identical.

Test Plan:
- Reset asserted mid-GRANT1 with a beat pending -> outputs drop to 0 immediately, state IDLE; after deassert, in0_val=1 gives in0_rdy=1 one cycle later.
- in0 sends a 3-beat transaction, out_rdy=1, while in1_val is held high -> 3 fires on in0; with the feature, out_val=0 for 2 cycles and mux_sel=0 during them, then in1_rdy=1 with mux_sel=mux_domain=1; without the feature, in1_rdy=1 on the cycle after the last in0 fire.
- Both valid from IDLE after reset -> in0 granted first (prio=0); after its 1-beat transaction, in1 is granted; next contention favours in0.
- in1 streams beats with in1_last=0, p_max_beats=8 -> release after the 8th fire, preempt=1 for exactly one cycle, in0 then granted if valid.
- out_rdy=0 for 5 cycles in GRANT0 with in0_val=1, in0_last=1 -> no fire, no release, beat counter unchanged; release on the first cycle out_rdy=1.
- Only in0 valid, back-to-back 1-beat transactions -> stays in GRANT0 with no idle cycle between them and no scrub.

Source files
------------

// File: rtl/vc_domain_arb2_ctrl.sv
// ---------------------------------------------------------------------------
// vc_domain_arb2_ctrl
//
// Domain-aware two-requester arbiter for a shared vc_Mux2_sd-style datapath.
// Requester 0 belongs to domain 0 and requester 1 belongs to domain 1. The
// block drives the mux select and domain label. A granted requester keeps
// ownership for a whole multi-beat transaction. Ownership is released on a
// last beat, or by a watchdog after p_max_beats beats. Round-robin priority
// flips on every release.
//
// Optional build macro: VC_DOMAIN_ARB_SCRUB_EN
//   When this macro is defined, every change of domain passes through a SCRUB
//   state lasting p_scrub_cycles idle cycles. This keeps beats of different
//   domains from being adjacent. When the macro is undefined, the SCRUB state
//   is never entered and a domain switch goes straight to the other grant.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in0_val     requester 0 (domain 0) has a beat
//   in0_last    current in0 beat closes its transaction
//   in0_rdy     in0 beat accepted this cycle
//   in1_val     requester 1 (domain 1) has a beat
//   in1_last    current in1 beat closes its transaction
//   in1_rdy     in1 beat accepted this cycle
//   out_val     shared output carries a valid beat
//   out_rdy     downstream accepts a beat
//   mux_sel     shared mux select (0 = in0, 1 = in1), registered
//   mux_domain  domain label to the shared mux, registered, tracks mux_sel
//   busy        controller is not idle, registered
//   preempt     one-cycle pulse after a watchdog release, registered
// ---------------------------------------------------------------------------
module vc_domain_arb2_ctrl #(
    parameter int p_max_beats    = 8,
    parameter int p_scrub_cycles = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in0_val,
    input  logic in0_last,
    output logic in0_rdy,
    input  logic in1_val,
    input  logic in1_last,
    output logic in1_rdy,
    output logic out_val,
    input  logic out_rdy,
    output logic mux_sel,
    output logic mux_domain,
    output logic busy,
    output logic preempt
);

    localparam int CW = $clog2(p_max_beats);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_SCRUB  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mux_sel_q, mux_sel_d;
    logic          busy_q, busy_d;
    logic          preempt_q, preempt_d;

`ifdef VC_DOMAIN_ARB_SCRUB_EN
    localparam int SCW = $clog2(p_scrub_cycles + 1);
    logic           pend_q, pend_d;
    logic [SCW-1:0] scnt_q, scnt_d;
`endif

    // Helper signals for the current owner and for a pending grant request.
    logic own_s;
    logic own_val_s;
    logic own_last_s;
    logic oth_val_s;
    logic fire_s;
    logic go_s;
    logic tgt_s;

    // Next-state, counter and select computation.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        mux_sel_d = mux_sel_q;
        preempt_d = 1'b0;
`ifdef VC_DOMAIN_ARB_SCRUB_EN
        pend_d    = pend_q;
        scnt_d    = scnt_q;
`endif
        own_s      = (state_q == ST_GRANT1);
        own_val_s  = own_s ? in1_val  : in0_val;
        own_last_s = own_s ? in1_last : in0_last;
        oth_val_s  = own_s ? in0_val  : in1_val;
        fire_s     = 1'b0;
        go_s       = 1'b0;
        tgt_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in0_val && in1_val) begin
                    go_s  = 1'b1;
                    tgt_s = prio_q;
                end else if (in0_val) begin
                    go_s  = 1'b1;
                    tgt_s = 1'b0;
                end else if (in1_val) begin
                    go_s  = 1'b1;
                    tgt_s = 1'b1;
                end else begin
                    go_s  = 1'b0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                fire_s = own_val_s & out_rdy;
                if (fire_s) begin
                    if (own_last_s || (cnt_q == CW'(p_max_beats - 1))) begin
                        // A beat-limit release that is not a natural last beat is a watchdog release.
                        preempt_d = ~own_last_s;
                        prio_d    = ~own_s;
                        cnt_d     = '0;
                        if (oth_val_s) begin
                            go_s  = 1'b1;
                            tgt_s = ~own_s;
                        end else begin
                            // The owner's val is high on a fire, so it keeps the grant for a
                            // fresh transaction. An empty grant falls back to IDLE next cycle.
                            state_d = state_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!own_val_s && (cnt_q == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCRUB: begin
`ifdef VC_DOMAIN_ARB_SCRUB_EN
                // The pending grant is entered even if its val has dropped meanwhile.
                if (scnt_q == SCW'(p_scrub_cycles - 1)) begin
                    state_d   = pend_q ? ST_GRANT1 : ST_GRANT0;
                    mux_sel_d = pend_q;
                    scnt_d    = '0;
                end else begin
                    scnt_d = scnt_q + SCW'(1);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A grant to the domain already on the mux is direct. A domain change may need a scrub.
        if (go_s) begin
`ifdef VC_DOMAIN_ARB_SCRUB_EN
            if (tgt_s != mux_sel_q) begin
                state_d = ST_SCRUB;
                pend_d  = tgt_s;
                scnt_d  = '0;
            end else begin
                state_d   = tgt_s ? ST_GRANT1 : ST_GRANT0;
                mux_sel_d = tgt_s;
            end
`else
            state_d   = tgt_s ? ST_GRANT1 : ST_GRANT0;
            mux_sel_d = tgt_s;
`endif
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            mux_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
`ifdef VC_DOMAIN_ARB_SCRUB_EN
            pend_q    <= 1'b0;
            scnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
`ifdef VC_DOMAIN_ARB_SCRUB_EN
            pend_q    <= pend_d;
            scnt_q    <= scnt_d;
`endif
        end
    end

    // The handshake is a same-cycle pass-through of the owner. Decoding the registered
    // state makes these signals drop to zero as soon as reset is asserted.
    assign out_val    = ((state_q == ST_GRANT0) & in0_val) | ((state_q == ST_GRANT1) & in1_val);
    assign in0_rdy    = (state_q == ST_GRANT0) & in0_val & out_rdy;
    assign in1_rdy    = (state_q == ST_GRANT1) & in1_val & out_rdy;
    assign mux_sel    = mux_sel_q;
    assign mux_domain = mux_sel_q;
    assign busy       = busy_q;
    assign preempt    = preempt_q;

endmodule

// File: tb/tb_vc_domain_arb2_ctrl.sv
module tb_vc_domain_arb2_ctrl;

    localparam int MAXB = 8;
`ifdef VC_DOMAIN_ARB_SCRUB_EN
    localparam int SCR = 2;
`else
    localparam int SCR = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in0_val, in0_last, in0_rdy;
    logic in1_val, in1_last, in1_rdy;
    logic out_val, out_rdy;
    logic mux_sel, mux_domain, busy, preempt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Transaction-level model state.
    int m_owner;    // -1 = nobody owns the datapath, else the owning requester
    int m_gap;      // idle scrub cycles still to run before m_pend is granted
    int m_pend;
    int m_sel;      // domain currently shown on the mux
    int m_prio;     // requester favoured on contention
    int m_beats;    // beats accepted in the current transaction
    bit m_preempt;

    vc_domain_arb2_ctrl #(.p_max_beats(MAXB), .p_scrub_cycles(2)) dut (
        .clk(clk), .reset(reset),
        .in0_val(in0_val), .in0_last(in0_last), .in0_rdy(in0_rdy),
        .in1_val(in1_val), .in1_last(in1_last), .in1_rdy(in1_rdy),
        .out_val(out_val), .out_rdy(out_rdy),
        .mux_sel(mux_sel), .mux_domain(mux_domain),
        .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: run did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_pend = 0; m_sel = 0;
        m_prio = 0; m_beats = 0; m_preempt = 1'b0;
    endtask

    task automatic start_grant(input int t);
        if (t != m_sel && SCR > 0) begin
            m_owner = -1;
            m_gap   = SCR;
            m_pend  = t;
        end else begin
            m_owner = t;
            m_sel   = t;
            m_beats = 0;
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sampled.
    task automatic model_step();
        bit v, l, ov;
        m_preempt = 1'b0;
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_owner = m_pend; m_sel = m_pend; m_beats = 0;
            end
        end else if (m_owner < 0) begin
            if (in0_val && in1_val) start_grant(m_prio);
            else if (in0_val)       start_grant(0);
            else if (in1_val)       start_grant(1);
        end else begin
            v  = (m_owner == 1) ? in1_val  : in0_val;
            l  = (m_owner == 1) ? in1_last : in0_last;
            ov = (m_owner == 1) ? in0_val  : in1_val;
            if (v && out_rdy) begin
                m_beats++;
                if (l || m_beats == MAXB) begin
                    m_preempt = !l;
                    m_prio    = 1 - m_owner;
                    m_beats   = 0;
                    if (ov) start_grant(1 - m_owner);
                end
            end else if (!v && m_beats == 0) begin
                m_owner = -1;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_val",    out_val,    (m_owner == 0) ? in0_val : (m_owner == 1) ? in1_val : 1'b0);
            chk("in0_rdy",    in0_rdy,    (m_owner == 0) && in0_val && out_rdy);
            chk("in1_rdy",    in1_rdy,    (m_owner == 1) && in1_val && out_rdy);
            chk("mux_sel",    mux_sel,    m_sel[0]);
            chk("mux_domain", mux_domain, m_sel[0]);
            chk("busy",       busy,       (m_owner >= 0) || (m_gap > 0));
            chk("preempt",    preempt,    m_preempt);
        end
    end

    task automatic drive(input bit v0, input bit l0, input bit v1, input bit l1, input bit ordy);
        in0_val = v0; in0_last = l0; in1_val = v1; in1_last = l1; out_rdy = ordy;
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        bit rv0, rl0, rv1, rl1, rordy;
        reset = 1'b1;
        in0_val = 1'b0; in0_last = 1'b0; in1_val = 1'b0; in1_last = 1'b0; out_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", mux_sel, 1'b0);
        chk("rst_preempt", preempt, 1'b0);
        chk("rst_out_val", out_val, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Three-beat in0 transaction while in1 waits.
        drive(1, 0, 1, 0, 1); chk("idle_no_rdy", in0_rdy, 1'b0); adv();
        drive(1, 0, 1, 0, 1); chk("grant0_first", in0_rdy, 1'b1); chk("in1_blocked", in1_rdy, 1'b0); adv();
        drive(1, 0, 1, 0, 1); chk("in0_beat2", in0_rdy, 1'b1); adv();
        drive(1, 1, 1, 0, 1); chk("in0_last_fire", in0_rdy, 1'b1); adv();
        for (int k = 0; k < SCR; k++) begin
            drive(0, 0, 1, 0, 1);
            chk("scrub_out_val", out_val, 1'b0);
            chk("scrub_sel", mux_sel, 1'b0);
            adv();
        end
        drive(0, 0, 1, 1, 1);
        chk("in1_grant_rdy", in1_rdy, 1'b1);
        chk("in1_sel", mux_sel, 1'b1);
        chk("in1_domain", mux_domain, 1'b1);
        adv();

        // in1 streams without a last beat until the watchdog releases it.
        for (int i = 0; i < MAXB; i++) begin
            drive(1, 0, 1, 0, 1);
            chk("wd_fire", in1_rdy, 1'b1);
            chk("wd_no_preempt", preempt, 1'b0);
            adv();
        end
        drive(1, 1, 0, 0, 0); chk("wd_preempt", preempt, 1'b1); adv();
        for (int k = 1; k < SCR; k++) begin
            drive(1, 1, 0, 0, 0); adv();
        end

        // Downstream stall in GRANT0, then release and back-to-back single beats.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0);
            chk("stall_rdy", in0_rdy, 1'b0);
            chk("stall_out_val", out_val, 1'b1);
            chk("stall_preempt", preempt, 1'b0);
            adv();
        end
        drive(1, 1, 0, 0, 1); chk("stall_release", in0_rdy, 1'b1); adv();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1);
            chk("b2b_rdy", in0_rdy, 1'b1);
            chk("b2b_busy", busy, 1'b1);
            adv();
        end

        // Randomized traffic with short and then long transactions.
        for (int i = 0; i < 3000; i++) begin
            rv0   = ($urandom_range(0, 3) != 0);
            rv1   = ($urandom_range(0, 3) != 0);
            rordy = ($urandom_range(0, 4) != 0);
            if (i < 1500) begin
                rl0 = ($urandom_range(0, 3) == 0);
                rl1 = ($urandom_range(0, 3) == 0);
            end else begin
                rl0 = ($urandom_range(0, 15) == 0);
                rl1 = ($urandom_range(0, 15) == 0);
            end
            drive(rv0, rl0, rv1, rl1, rordy);
            adv();
        end

        // Steer into GRANT1 with a stalled beat, then reset in the middle of it.
        for (int i = 0; i < 16 && m_owner != 1; i++) begin
            drive(0, 0, 1, 0, 0);
            adv();
        end
        drive(0, 0, 1, 0, 1);
        chk("pre_rst_grant1", in1_rdy, 1'b1);
        #1;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rst_mid_out_val", out_val, 1'b0);
        chk("rst_mid_in1_rdy", in1_rdy, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_sel", mux_sel, 1'b0);
        chk("rst_mid_preempt", preempt, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        drive(1, 1, 0, 0, 1); chk("post_rst_idle", in0_rdy, 1'b0); adv();
        drive(1, 1, 0, 0, 1); chk("post_rst_grant0", in0_rdy, 1'b1); adv();
        drive(0, 0, 0, 0, 1); adv();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
